// File: rtl/fifo_axis_tx.sv
// FIFO reader that drives an AXI-Stream master through a 2-entry registered skid buffer.
// Define FIFO_AXIS_TX_STATS_EN to build the packet length/count and keep-legality logic.
module fifo_axis_tx #(
  parameter int WIDTH = 256,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  input  logic [31:0]      fifo_rd_keep,
  input  logic             fifo_rd_last,
  input  logic             fifo_empty,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic [31:0]      m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             pkt_done,
  output logic [LEN_W-1:0] pkt_len,
  output logic [31:0]      pkt_count,
  output logic             keep_err
);

  localparam int KW = WIDTH / 8;
  localparam logic [31:0] KEEP_MASK = (KW == 32) ? 32'hFFFF_FFFF : ((32'd1 << KW) - 32'd1);

  logic [1:0]       occ_reg;
  logic [WIDTH-1:0] tail_data_reg;
  logic [31:0]      tail_keep_reg;
  logic             tail_last_reg;
  logic [31:0]      keep_in;
  logic             pop;
  logic             xfer;

  // The head entry lives directly in the m_axis_* output registers.
  assign keep_in    = fifo_rd_keep & KEEP_MASK;
  assign pop        = rst_n && !fifo_empty && (occ_reg != 2'd2);
  assign xfer       = m_axis_tvalid && m_axis_tready;
  assign fifo_rd_en = pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg       <= 2'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      tail_data_reg <= '0;
      tail_keep_reg <= '0;
      tail_last_reg <= 1'b0;
    end else begin
      case ({pop, xfer})
        2'b10: begin
          if (occ_reg == 2'd0) begin
            m_axis_tdata <= fifo_rd_data;
            m_axis_tkeep <= keep_in;
            m_axis_tlast <= fifo_rd_last;
          end else begin
            tail_data_reg <= fifo_rd_data;
            tail_keep_reg <= keep_in;
            tail_last_reg <= fifo_rd_last;
          end
          occ_reg       <= occ_reg + 2'd1;
          m_axis_tvalid <= 1'b1;
        end
        2'b01: begin
          if (occ_reg == 2'd2) begin
            m_axis_tdata <= tail_data_reg;
            m_axis_tkeep <= tail_keep_reg;
            m_axis_tlast <= tail_last_reg;
          end
          occ_reg       <= occ_reg - 2'd1;
          m_axis_tvalid <= (occ_reg == 2'd2);
        end
        2'b11: begin
          // Occupancy is 1 here (pop needs <2, transfer needs >0): new beat goes straight to the head.
          m_axis_tdata <= fifo_rd_data;
          m_axis_tkeep <= keep_in;
          m_axis_tlast <= fifo_rd_last;
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_AXIS_TX_STATS_EN
  localparam int SW = LEN_W + 1;

  typedef enum logic {S_IDLE, S_PKT} state_t;

  state_t           state_reg;
  logic [LEN_W-1:0] acc_reg;
  logic [5:0]       pop_cnt;
  logic [LEN_W-1:0] acc_base;
  logic [SW-1:0]    sum_wide;
  logic [LEN_W-1:0] sum_sat;
  logic             keep_full;
  logic             keep_contig;

  always_comb begin
    pop_cnt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      pop_cnt = pop_cnt + {5'd0, m_axis_tkeep[i]};
    end
  end

  // A packet always starts counting from zero, whatever the accumulator holds.
  assign acc_base    = (state_reg == S_IDLE) ? '0 : acc_reg;
  assign sum_wide    = {1'b0, acc_base} + SW'(pop_cnt);
  assign sum_sat     = sum_wide[LEN_W] ? '1 : sum_wide[LEN_W-1:0];
  assign keep_full   = (m_axis_tkeep == KEEP_MASK);
  assign keep_contig = (m_axis_tkeep != 32'd0) &&
                       ((m_axis_tkeep & (m_axis_tkeep + 32'd1)) == 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      acc_reg   <= '0;
      pkt_done  <= 1'b0;
      pkt_len   <= '0;
      pkt_count <= '0;
      keep_err  <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      keep_err <= 1'b0;
      if (xfer) begin
        keep_err <= m_axis_tlast ? !keep_contig : !keep_full;
        if (m_axis_tlast) begin
          pkt_len   <= sum_sat;
          acc_reg   <= '0;
          pkt_count <= pkt_count + 32'd1;
          pkt_done  <= 1'b1;
          state_reg <= S_IDLE;
        end else begin
          acc_reg   <= sum_sat;
          state_reg <= S_PKT;
        end
      end
    end
  end
`else
  assign pkt_done  = 1'b0;
  assign pkt_len   = '0;
  assign pkt_count = '0;
  assign keep_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_axis_tx.sv
// Randomized bench for fifo_axis_tx: emulates the FIFO, predicts the stream and packet stats
// from a queue-level model, and checks every cycle plus a few literal scenario results.
module tb_fifo_axis_tx;
  localparam int WIDTH = 256;
  localparam int LEN_W = 16;
  localparam int KW    = WIDTH / 8;
  localparam int MAXL  = (1 << LEN_W) - 1;
  localparam logic [31:0] KMASK = (KW == 32) ? 32'hFFFF_FFFF : ((32'd1 << KW) - 32'd1);
`ifdef FIFO_AXIS_TX_STATS_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [31:0]      k;
    logic             l;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rd_data;
  logic [31:0]      fifo_rd_keep;
  logic             fifo_rd_last;
  logic             fifo_empty;
  logic [WIDTH-1:0] m_axis_tdata;
  logic [31:0]      m_axis_tkeep;
  logic             m_axis_tlast;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             pkt_done;
  logic [LEN_W-1:0] pkt_len;
  logic [31:0]      pkt_count;
  logic             keep_err;

  fifo_axis_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_keep(fifo_rd_keep),
    .fifo_rd_last(fifo_rd_last), .fifo_empty(fifo_empty),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_count(pkt_count), .keep_err(keep_err)
  );

  always #5 clk = ~clk;

  beat_t       src_q[$];
  beat_t       exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          acc = 0;
  int          exp_len = 0;
  logic [31:0] exp_cnt = '0;
  bit          exp_done = 1'b0;
  bit          exp_kerr = 1'b0;
  int          kerr_seen = 0;
  int          xfers = 0;
  int          tready_mode = 1;
  bit          hide = 1'b0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit keep_legal(input logic [31:0] k, input bit last);
    logic [32:0] m;
    if (!last) return k == KMASK;
    for (int n = 1; n <= KW; n++) begin
      m = (33'd1 << n) - 33'd1;
      if (k == m[31:0]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic beat_t mk_beat(input logic [31:0] k, input bit last);
    beat_t b;
    for (int i = 0; i < WIDTH / 32; i++) b.d[i*32 +: 32] = $urandom;
    b.k = k;
    b.l = last;
    return b;
  endfunction

  task automatic drive();
    hide = (tready_mode == 2) && ($urandom_range(0, 4) == 0);
    fifo_empty = (src_q.size() == 0) || hide;
    if (src_q.size() > 0) {fifo_rd_data, fifo_rd_keep, fifo_rd_last} = src_q[0];
    else {fifo_rd_data, fifo_rd_keep, fifo_rd_last} = '0;
    case (tready_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic model_xfer(input beat_t b);
    logic [31:0] k;
    int s;
    k = b.k & KMASK;
    s = acc + $countones(k);
    if (s > MAXL) s = MAXL;
    if (!keep_legal(k, b.l)) exp_kerr = 1'b1;
    if (b.l) begin
      exp_len  = s;
      acc      = 0;
      exp_cnt  = exp_cnt + 32'd1;
      exp_done = 1'b1;
    end else begin
      acc = s;
    end
  endtask

  // One clock: compare at the falling edge, advance the model, then drive new inputs.
  task automatic cycle();
    bit    pop;
    bit    xfer;
    beat_t h;
    @(negedge clk);
    pop = !fifo_empty && (exp_q.size() < 2);
    chk("rd_en", fifo_rd_en, pop);
    chk("tvalid", m_axis_tvalid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      chk("tdata", m_axis_tdata, h.d);
      chk("tkeep", m_axis_tkeep, h.k & KMASK);
      chk("tlast", m_axis_tlast, h.l);
    end
    chk("pkt_done", pkt_done, ST & exp_done);
    chk("pkt_len", pkt_len, ST ? exp_len : 0);
    chk("pkt_count", pkt_count, ST ? exp_cnt : 32'd0);
    chk("keep_err", keep_err, ST & exp_kerr);
    if (keep_err) kerr_seen++;
    exp_done = 1'b0;
    exp_kerr = 1'b0;
    xfer = (exp_q.size() > 0) && m_axis_tready;
    if (xfer) begin
      model_xfer(exp_q.pop_front());
      xfers++;
    end
    if (pop) exp_q.push_back(src_q.pop_front());
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int budget, output int used);
    used = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && used < budget) begin
      cycle();
      used++;
    end
    chk("drain_timeout", src_q.size() + exp_q.size(), 0);
    cycle();
    cycle();
  endtask

  initial begin
    int    n;
    int    nb;
    int    x0;
    logic [31:0] k;
    logic [32:0] m;

    rst_n = 1'b0;
    tready_mode = 1;
    src_q.push_back(mk_beat(32'hFFFF_FFFF, 1'b1));
    drive();
    #3;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tkeep", m_axis_tkeep, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_pkt_len", pkt_len, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_keep_err", keep_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();

    // Basic single-beat packet.
    drain(20, n);
    chk("basic_len", pkt_len, ST ? 32 : 0);
    chk("basic_count", pkt_count, ST ? 1 : 0);

    // Streaming: 3 full beats plus a 4-byte tail.
    kerr_seen = 0;
    for (int i = 0; i < 3; i++) src_q.push_back(mk_beat(32'hFFFF_FFFF, 1'b0));
    src_q.push_back(mk_beat(32'h0000_000F, 1'b1));
    drive();
    drain(20, n);
    chk("stream_cycles", n, 5);
    chk("stream_len", pkt_len, ST ? 100 : 0);
    chk("stream_kerr", kerr_seen, 0);

    // Backpressure with 3 beats queued.
    tready_mode = 0;
    src_q.push_back(mk_beat(32'hFFFF_FFFF, 1'b0));
    src_q.push_back(mk_beat(32'hFFFF_FFFF, 1'b0));
    src_q.push_back(mk_beat(32'h0000_00FF, 1'b1));
    drive();
    for (int i = 0; i < 5; i++) cycle();
    chk("bp_rd_en_low", fifo_rd_en, 0);
    chk("bp_tvalid", m_axis_tvalid, 1);
    tready_mode = 1;
    drive();
    drain(20, n);
    chk("bp_len", pkt_len, ST ? 72 : 0);

    // Illegal keeps are forwarded and flagged.
    kerr_seen = 0;
    src_q.push_back(mk_beat(32'h0000_FFFF, 1'b0));
    src_q.push_back(mk_beat(32'h0000_0005, 1'b1));
    drive();
    drain(20, n);
    chk("ill_len", pkt_len, ST ? 18 : 0);
    chk("ill_kerr_pulses", kerr_seen, ST ? 2 : 0);

    // Long packet saturates the length accumulator.
    for (int i = 0; i < 2100; i++) src_q.push_back(mk_beat(32'hFFFF_FFFF, 1'b0));
    src_q.push_back(mk_beat(32'hFFFF_FFFF, 1'b1));
    drive();
    drain(2200, n);
    chk("sat_len", pkt_len, ST ? MAXL : 0);

    // Random packets, random keeps, random FIFO gaps and backpressure.
    tready_mode = 2;
    for (int p = 0; p < 40; p++) begin
      nb = $urandom_range(1, 8);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 4) == 0) k = $urandom;
        else if (b == nb - 1) begin
          m = (33'd1 << $urandom_range(1, KW)) - 33'd1;
          k = m[31:0];
        end else k = KMASK;
        src_q.push_back(mk_beat(k, b == nb - 1));
      end
    end
    drive();
    drain(3000, n);

    // Asynchronous reset in the middle of a 4-beat packet.
    tready_mode = 1;
    for (int i = 0; i < 4; i++) src_q.push_back(mk_beat(32'hFFFF_FFFF, i == 3));
    drive();
    x0 = xfers;
    n = 0;
    while (xfers - x0 < 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("mid_xfers", xfers - x0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    acc = 0;
    exp_len = 0;
    exp_cnt = '0;
    exp_done = 1'b0;
    exp_kerr = 1'b0;
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_count", pkt_count, 0);
    chk("mid_rst_len", pkt_len, 0);
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_rd_en_hold", fifo_rd_en, 0);
    rst_n = 1'b1;
    src_q.delete();
    src_q.push_back(mk_beat(32'hFFFF_FFFF, 1'b1));
    drive();
    drain(20, n);
    chk("post_rst_count", pkt_count, ST ? 1 : 0);
    chk("post_rst_len", pkt_len, ST ? 32 : 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
